tree_walker: RTL and testbench

Sequential, table-driven binary decision-tree classifier. It is the programmable successor to our generated fixed-tree classifier modules. Instead of a hard-wired mux cascade, it walks a node table loaded at run time, visiting one node per clock, with valid/ready handshakes on both sides. It sits between the feature-vector producer and the class-result consumer; one tree fits any feature width, node count and class width set by parameters.

---
 rtl/tree_walker.sv | 148 ++++++++++++++
 tb/tb_tree_walker.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_walker.sv
// rtl/tree_walker.sv - table-driven binary decision-tree classifier, one node per clock
// Optional TREE_WALKER_STATS_EN adds saturating result/error handshake counters.

module tree_walker #(
    parameter int  N_FEAT    = 51,
    parameter int  N_NODES   = 64,
    parameter int  CLASS_W   = 2,
    parameter int  MAX_DEPTH = 16,
    localparam int FIDX_W    = $clog2(N_FEAT),
    localparam int ADDR_W    = $clog2(N_NODES),
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1),
    localparam int NODE_W    = 1 + FIDX_W + 2 * ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [NODE_W-1:0]  cfg_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_FEAT-1:0]  in_feat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic [DEPTH_W-1:0] out_depth,
    output logic               out_err,
    output logic               busy
`ifdef TREE_WALKER_STATS_EN
    ,
    output logic [31:0]        stat_results,
    output logic [15:0]        stat_errors
`endif
);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t             state_q, state_d;
    logic [NODE_W-1:0]  tbl_q [N_NODES];
    logic [N_FEAT-1:0]  feat_q, feat_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic               err_q, err_d;

    logic [NODE_W-1:0]  node;
    logic               node_leaf;
    logic [FIDX_W-1:0]  node_fidx;
    logic [ADDR_W-1:0]  node_hi, node_lo, child;
    logic               fidx_bad, child_bad, depth_max, feat_bit, fault, cfg_ok;

    assign node      = tbl_q[ptr_q];
    assign node_leaf = node[NODE_W-1];
    assign node_fidx = node[NODE_W-2 -: FIDX_W];
    assign node_hi   = node[2*ADDR_W-1 -: ADDR_W];
    assign node_lo   = node[ADDR_W-1:0];

    // Out-of-range feature index reads as 0 so the mux never selects past the vector.
    assign fidx_bad  = {1'b0, node_fidx} >= (FIDX_W+1)'(N_FEAT);
    assign feat_bit  = fidx_bad ? 1'b0 : feat_q[node_fidx];
    assign child     = feat_bit ? node_hi : node_lo;
    assign child_bad = {1'b0, child} >= (ADDR_W+1)'(N_NODES);
    assign depth_max = depth_q == DEPTH_W'(MAX_DEPTH);
    assign fault     = fidx_bad | child_bad | depth_max;
    assign cfg_ok    = (state_q == IDLE) && cfg_we && ({1'b0, cfg_addr} < (ADDR_W+1)'(N_NODES));

    always_comb begin
        state_d = state_q;
        feat_d  = feat_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        class_d = class_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    feat_d  = in_feat;
                    ptr_d   = '0;
                    depth_d = '0;
                    state_d = WALK;
                end
            end
            WALK: begin
                if (node_leaf) begin
                    class_d = node_lo[CLASS_W-1:0];
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (fault) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ptr_d   = child;
                    depth_d = depth_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            feat_q  <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
            class_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_NODES; i++) tbl_q[i] <= {1'b1, (NODE_W-1)'(0)};
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            class_q <= class_d;
            err_q   <= err_d;
            if (cfg_ok) tbl_q[cfg_addr] <= cfg_data;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_class = class_q;
    assign out_depth = depth_q;
    assign out_err   = err_q;

`ifdef TREE_WALKER_STATS_EN
    logic [31:0] stat_results_q;
    logic [15:0] stat_errors_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_results_q <= '0;
            stat_errors_q  <= '0;
        end else if (state_q == DONE && out_ready) begin
            if (stat_results_q != '1) stat_results_q <= stat_results_q + 1'b1;
            if (err_q && stat_errors_q != '1) stat_errors_q <= stat_errors_q + 1'b1;
        end
    end

    assign stat_results = stat_results_q;
    assign stat_errors  = stat_errors_q;
`endif

endmodule

// File: tb/tb_tree_walker.sv
// tb/tb_tree_walker.sv - randomized model-checked bench for tree_walker
module tb_tree_walker;
    localparam int NF = 51;
    localparam int NN = 48;
    localparam int MD = 16;

    logic        clk = 1'b0;
    logic        rst, cfg_we, in_valid, out_ready;
    logic [5:0]  cfg_addr;
    logic [18:0] cfg_data;
    logic [50:0] in_feat;
    logic        in_ready, out_valid, out_err, busy;
    logic [1:0]  out_class;
    logic [4:0]  out_depth;
`ifdef TREE_WALKER_STATS_EN
    logic [31:0] stat_results;
    logic [15:0] stat_errors;
`endif

    tree_walker #(.N_NODES(NN)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_depth(out_depth), .out_err(out_err), .busy(busy)
`ifdef TREE_WALKER_STATS_EN
        , .stat_results(stat_results), .stat_errors(stat_errors)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Reference model state
    logic [18:0] m_tbl [NN];
    int m_phase = 0, m_cnt = 0, e_cls = 0, e_dep = 0, e_err = 0;
    int s_res = 0, s_err = 0;
    bit obs_on = 0;
    int obs_cnt = 0, obs_lat = -1;
    int last_cls = -1, last_dep = -1, last_err = -1, last_lat = -1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [18:0] nd(input logic leaf, input int fidx, input int hi, input int lo);
        logic [31:0] a, b, c;
        a = fidx; b = hi; c = lo;
        return {leaf, a[5:0], b[5:0], c[5:0]};
    endfunction

    // Walks the table by the classifier rules: leaf ends, faults end with error.
    function automatic void predict(input logic [50:0] f, output int cls, output int dep, output int err);
        int p, d, fx, ch;
        logic [18:0] w;
        logic b;
        p = 0; d = 0; cls = 0; dep = 0; err = 1;
        for (int k = 0; k <= MD + 1; k++) begin
            w = m_tbl[p];
            if (w[18]) begin
                cls = int'(w[1:0]); dep = d; err = 0;
                return;
            end
            fx = int'(w[17:12]);
            b = 1'b0;
            if (fx < NF) b = f[fx];
            ch = b ? int'(w[11:6]) : int'(w[5:0]);
            if (fx >= NF || ch >= NN || d == MD) begin
                cls = 0; dep = d; err = 1;
                return;
            end
            p = ch;
            d++;
        end
    endfunction

    always @(negedge clk) begin
        if (obs_on) begin
            obs_cnt++;
            if (out_valid && obs_lat < 0) obs_lat = obs_cnt;
        end
        if (chk_en) begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            if (m_phase == 2) begin
                chk("out_class", out_class, e_cls);
                chk("out_depth", out_depth, e_dep);
                chk("out_err", out_err, e_err);
            end
`ifdef TREE_WALKER_STATS_EN
            chk("stat_results", stat_results, s_res);
            chk("stat_errors", stat_errors, s_err);
`endif
        end
        if (rst) begin
            for (int i = 0; i < NN; i++) m_tbl[i] = nd(1'b1, 0, 0, 0);
            m_phase = 0; s_res = 0; s_err = 0; obs_on = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (cfg_we && int'(cfg_addr) < NN) m_tbl[cfg_addr] = cfg_data;
                    if (in_valid) begin
                        predict(in_feat, e_cls, e_dep, e_err);
                        m_phase = 1; m_cnt = 0;
                        obs_on = 1; obs_cnt = -1; obs_lat = -1;
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == e_dep + 1) m_phase = 2;
                end
                default: begin
                    if (out_ready) begin
                        last_cls = int'(out_class); last_dep = int'(out_depth);
                        last_err = int'(out_err); last_lat = obs_lat;
                        obs_on = 0; m_phase = 0;
                        s_res++;
                        if (e_err != 0) s_err++;
                    end
                end
            endcase
        end
    end

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting on DUT at %0t", name, $time);
    endtask

    task automatic accept(input logic [50:0] f);
        int n;
        in_valid = 1'b1; in_feat = f; n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("accept");
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic collect(input int hold, input bit pre);
        int n;
        out_ready = pre; n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout("out_valid");
        if (!pre) begin
            repeat (hold) begin @(posedge clk); #1; end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [18:0] data);
        cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic pin(input string tag, input int c, input int d, input int e, input int l);
        chk({tag, "_class"}, last_cls, c);
        chk({tag, "_depth"}, last_dep, d);
        chk({tag, "_err"}, last_err, e);
        if (l >= 0) chk({tag, "_latency"}, last_lat, l);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [50:0] f;
        logic [63:0] r64;
        int lb, fx, hi, lo;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_depth", out_depth, 0);
        chk("rst_out_err", out_err, 0);

        accept('0); collect(0, 0);
        pin("empty", 0, 0, 0, 1);

        wr(0, nd(0, 50, 1, 2)); wr(1, nd(1, 0, 0, 0)); wr(2, nd(0, 18, 3, 4));
        wr(3, nd(1, 0, 0, 2)); wr(4, nd(1, 0, 0, 1));
        f = '0; f[50] = 1'b1;
        accept(f); collect(0, 0);
        pin("hi50", 0, 1, 0, 2);
        f = '0; f[18] = 1'b1;
        accept(f); collect(1, 0);
        pin("lo50hi18", 2, 2, 0, 3);
        accept('0); collect(0, 1);
        pin("lo50lo18", 1, 2, 0, 3);

        // Second vector held during backpressure must wait for the handshake.
        f = '0; f[18] = 1'b1;
        accept(f);
        f = '0; f[50] = 1'b1;
        in_valid = 1'b1; in_feat = f;
        collect(5, 0);
        pin("bp_first", 2, 2, 0, -1);
        chk("bp_ready_after", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(0, 0);
        pin("bp_second", 0, 1, 0, 2);

        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = nd(1, 0, 0, 3);
        accept(f); collect(0, 0);
        pin("same_cycle_wr", 3, 1, 0, 2);
        accept(f); wr(1, nd(1, 0, 0, 1)); collect(0, 0);
        pin("dropped_wr", 3, 1, 0, 2);

        wr(0, nd(0, 0, 0, 0));
        accept('0); collect(0, 0);
        pin("self_loop", 0, MD, 1, MD + 1);
        wr(0, nd(0, 0, NN, 0));
        f = '0; f[0] = 1'b1;
        accept(f); collect(0, 0);
        pin("child_fault", 0, 0, 1, 1);
        wr(0, nd(0, 55, 1, 2));
        accept('0); collect(0, 0);
        pin("fidx_fault", 0, 0, 1, 1);

        wr(0, nd(0, 0, 0, 0));
        accept('0);
        repeat (3) begin @(posedge clk); #1; end
        do_reset();
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        accept('0); collect(0, 0);
        pin("cleared", 0, 0, 0, 1);

        for (int t = 0; t < 12; t++) begin
            for (int a = 0; a < NN; a++) begin
                lb = ($urandom_range(0, 9) < 4) ? 1 : 0;
                fx = ($urandom_range(0, 15) == 0) ? $urandom_range(NF, 63) : $urandom_range(0, NF - 1);
                hi = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range((a < NN - 1) ? a + 1 : 0, NN - 1);
                lo = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range((a < NN - 1) ? a + 1 : 0, NN - 1);
                wr(a, nd(lb[0], fx, hi, lo));
            end
            for (int v = 0; v < 8; v++) begin
                r64 = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) begin
                    cfg_we = 1'b1; cfg_addr = 6'($urandom_range(0, 63)); cfg_data = 19'($urandom);
                end
                accept(r64[50:0]);
                if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 63), 19'($urandom));
                collect($urandom_range(0, 3), $urandom_range(0, 3) == 0);
            end
        end

        do_reset();
        for (int k = 0; k < 3; k++) begin
            r64 = {$urandom, $urandom};
            accept(r64[50:0]); collect(0, 0);
        end
        wr(0, nd(0, 60, 0, 0));
        accept('0); collect(0, 0);
        pin("stats_fault", 0, 0, 1, 1);
`ifdef TREE_WALKER_STATS_EN
        chk("stat_results_4", stat_results, 4);
        chk("stat_errors_1", stat_errors, 1);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
